pc_seq_ctrl: RTL and testbench
==============================

// Module: pc_seq_ctrl
// PURPOSE
// - Multi-cycle sequencer for the NPC program counter: owns the PC register, drives the IFU fetch handshake,
//   waits for EXU completion, selects next PC (seq/branch/jump/trap/mret) and commits it once per instruction.
// - Sits between IFU, EXU and CSR unit; replaces free-running PC update with an explicit per-instruction FSM.
// PARAMETERS
// - XLEN      32            datapath / address width
// - RESET_PC  32'h8000_0000 PC value loaded on reset
// - CNT_W     64            width of retired-instruction counter
// PORTS
// - clk            in   1     clock, all state on posedge
// - rst            in   1     synchronous, active-high reset
// - ifu_req_valid  out  1     fetch request valid (high only in FETCH)
// - ifu_req_addr   out  XLEN  fetch address = pc
// - ifu_req_ready  in   1     IFU accepts request
// - ifu_resp_valid in   1     instruction returned by IFU
// - exu_done       in   1     EXU finished current instruction; redirect inputs valid this cycle
// - br_taken       in   1     conditional branch taken
// - jump           in   1     jal/jalr
// - jump_target    in   XLEN  branch/jump target
// - trap           in   1     exception/ecall
// - trap_vec       in   XLEN  mtvec
// - mret           in   1     return from trap
// - mepc           in   XLEN  mret target
// - pc             out  XLEN  current PC
// - dnpc           out  XLEN  latched next PC (valid in COMMIT)
// - pc_wen         out  1     one-cycle pulse when pc updates
// - instret        out  CNT_W retired-instruction count
// - misalign_exc   out  1     target-misaligned pulse (PC_MISALIGN_TRAP_EN only, else tied 0)
// BEHAVIOUR
// - Reset: state=FETCH, pc=RESET_PC, dnpc=RESET_PC, pc_wen=0, instret=0, misalign_exc=0, ifu_req_valid=0 that cycle.
// - States: FETCH -> (ifu_req_ready) WAIT -> (ifu_resp_valid) EXEC -> (exu_done) COMMIT -> FETCH (unconditional).
// - FETCH: ifu_req_valid=1, addr=pc; stays until ifu_req_ready. Response before acceptance ignored.
// - WAIT/EXEC: hold; exu_done outside EXEC ignored; ifu_resp_valid outside WAIT ignored.
// - EXEC with exu_done: dnpc latched by priority trap>mret>(jump|br_taken)>pc+4; inputs sampled only here.
// - COMMIT: pc<=dnpc, pc_wen=1 this cycle only, instret+=1 unless trap (trapped instr does not retire).
// - Minimum 4 cycles/instr (req_ready and resp_valid same cycle as state entry).
// - Arithmetic: pc+4 modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000); instret wraps at 2^CNT_W.
// - rst mid-operation: any state aborts to reset values next edge; in-flight fetch response discarded.
// - Simultaneous trap+mret+jump: trap wins; mret+jump: mret wins.
// CONFIGURATION
// - PC_MISALIGN_TRAP_EN defined: non-trap redirect target with [1:0]!=0 -> dnpc=trap_vec, misalign_exc pulses
//   in COMMIT, instret not incremented.
// - Undefined: target[1:0] forced to 2'b00, misalign_exc tied 0.
// STRUCTURE
// - npc_pkg: pc_state_e {FETCH,WAIT,EXEC,COMMIT}, redir_e {SEQ,BR,JMP,TRAP,MRET}, RESET_PC default, ILEN_BYTES=4.
// - Sub-module pc_next_sel: combinational priority mux + pc+4 adder + alignment check; FSM/regs in pc_seq_ctrl.
// TESTING
// - Reset then ready/resp/done each 1 cycle, no redirect -> pc 0x8000_0000,0x8000_0004; pc_wen every 4th cycle.
// - jump=1, target=0x8000_0100 -> next fetch addr 0x8000_0100, instret+1.
// - trap=1,mret=1,jump=1 together, trap_vec=0x8000_0200 -> pc=0x8000_0200, instret unchanged.
// - ifu_req_ready held low 5 cycles -> ifu_req_valid stays high, addr stable, no pc_wen.
// - rst asserted in EXEC -> next cycle pc=0x8000_0000, state FETCH, instret=0.
// - PC_MISALIGN_TRAP_EN, target=0x8000_0102 -> misalign_exc=1 one cycle, pc=trap_vec; without: pc=0x8000_0100.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC program-counter sequencer.
package npc_pkg;

    localparam int          XLEN_DFLT     = 32;
    localparam logic [31:0] RESET_PC_DFLT = 32'h8000_0000;
    localparam int          ILEN_BYTES    = 4;

    // Per-instruction sequencer phases.
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        EXEC   = 2'd2,
        COMMIT = 2'd3
    } pc_state_e;

    // Source selected for the next PC.
    typedef enum logic [2:0] {
        SEQ  = 3'd0,
        BR   = 3'd1,
        JMP  = 3'd2,
        TRAP = 3'd3,
        MRET = 3'd4
    } redir_e;

    // A target is misaligned when it is not on an instruction boundary.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Fetch handshake between the PC sequencer (master) and the IFU (slave).
interface pc_seq_ctrl_if #(
    parameter int XLEN = 32
);
    logic            ifu_req_valid;
    logic [XLEN-1:0] ifu_req_addr;
    logic            ifu_req_ready;
    logic            ifu_resp_valid;

    modport master (
        output ifu_req_valid,
        output ifu_req_addr,
        input  ifu_req_ready,
        input  ifu_resp_valid
    );

    modport slave (
        input  ifu_req_valid,
        input  ifu_req_addr,
        output ifu_req_ready,
        output ifu_resp_valid
    );
endinterface

// File: rtl/pc_seq_ctrl_next_sel.sv
// Next-PC selection: priority mux trap > mret > jump/branch > pc+4,
// plus the target alignment policy.
// Build option PC_MISALIGN_TRAP_EN: a misaligned non-trap redirect target
// diverts to trap_vec and flags misalign; otherwise the target's low two
// bits are cleared.
module pc_next_sel
    import npc_pkg::*;
#(
    parameter int XLEN = XLEN_DFLT
) (
    input  logic [XLEN-1:0] pc,
    input  logic            br_taken,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            mret,
    input  logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] npc,
    output logic            misalign,
    output logic            retire
);

    redir_e          sel;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] tgt;

    // Sequential successor; wraps naturally at 2^XLEN.
    assign seq_pc = pc + XLEN'(ILEN_BYTES);

    // Resolve the redirect source by fixed priority.
    always_comb begin
        sel = SEQ;
        if (trap)
            sel = TRAP;
        else if (mret)
            sel = MRET;
        else if (jump)
            sel = JMP;
        else if (br_taken)
            sel = BR;
    end

    // Pick the redirect target for mret vs. jump/branch.
    always_comb begin
        tgt = jump_target;
        if (sel == MRET)
            tgt = mepc;
    end

    // Form the next PC and decide whether the instruction retires.
    always_comb begin
        npc      = seq_pc;
        misalign = 1'b0;
        retire   = 1'b1;
        case (sel)
            TRAP: begin
                npc    = trap_vec;
                retire = 1'b0;
            end
            MRET, JMP, BR: begin
`ifdef PC_MISALIGN_TRAP_EN
                if (is_misaligned(tgt[1:0])) begin
                    npc      = trap_vec;
                    misalign = 1'b1;
                    retire   = 1'b0;
                end else begin
                    npc = tgt;
                end
`else
                npc = tgt & ~XLEN'(3);
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// NPC program-counter sequencer: one FETCH/WAIT/EXEC/COMMIT pass per
// instruction, owning pc, the latched next PC and the retired count.
// Build option PC_MISALIGN_TRAP_EN enables the misaligned-target trap
// (see pc_next_sel); without it misalign_exc stays 0.
//
//   state  | meaning
//   -------+-------------------------------------------------------
//   FETCH  | request fetch at pc, wait for IFU to accept
//   WAIT   | wait for the IFU instruction response
//   EXEC   | wait for exu_done, latch next PC from redirect inputs
//   COMMIT | pc <= dnpc, pulse pc_wen, count retired instruction
module pc_seq_ctrl
    import npc_pkg::*;
#(
    parameter int              XLEN     = XLEN_DFLT,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DFLT),
    parameter int              CNT_W    = 64
) (
    input  logic              clk,
    input  logic              rst,
    pc_seq_ctrl_if.master     ifu,
    input  logic              exu_done,
    input  logic              br_taken,
    input  logic              jump,
    input  logic [XLEN-1:0]   jump_target,
    input  logic              trap,
    input  logic [XLEN-1:0]   trap_vec,
    input  logic              mret,
    input  logic [XLEN-1:0]   mepc,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   dnpc,
    output logic              pc_wen,
    output logic [CNT_W-1:0]  instret,
    output logic              misalign_exc
);

    pc_state_e       state;
    pc_state_e       state_nxt;
    logic            req_valid;
    logic            latch_en;
    logic            commit;
    logic [XLEN-1:0] npc;
    logic            npc_misalign;
    logic            npc_retire;
    logic            misalign_q;
    logic            retire_q;

    pc_next_sel #(
        .XLEN (XLEN)
    ) u_next_sel (
        .pc          (pc),
        .br_taken    (br_taken),
        .jump        (jump),
        .jump_target (jump_target),
        .trap        (trap),
        .trap_vec    (trap_vec),
        .mret        (mret),
        .mepc        (mepc),
        .npc         (npc),
        .misalign    (npc_misalign),
        .retire      (npc_retire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= FETCH;
        else
            state <= state_nxt;
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_nxt = state;
        req_valid = 1'b0;
        latch_en  = 1'b0;
        commit    = 1'b0;
        case (state)
            FETCH: begin
                req_valid = 1'b1;
                if (ifu.ifu_req_ready)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (ifu.ifu_resp_valid)
                    state_nxt = EXEC;
            end
            EXEC: begin
                if (exu_done) begin
                    latch_en  = 1'b1;
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                commit    = 1'b1;
                state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Redirect inputs are only meaningful in the exu_done cycle, so the
    // chosen next PC and its side effects are captured there.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            dnpc       <= RESET_PC;
            instret    <= '0;
            misalign_q <= 1'b0;
            retire_q   <= 1'b0;
        end else begin
            if (latch_en) begin
                dnpc       <= npc;
                misalign_q <= npc_misalign;
                retire_q   <= npc_retire;
            end
            if (commit) begin
                pc <= dnpc;
                if (retire_q)
                    instret <= instret + CNT_W'(1);
            end
        end
    end

    // Outputs are held quiet during the reset cycle.
    assign ifu.ifu_req_valid = req_valid & ~rst;
    assign ifu.ifu_req_addr  = pc;
    assign pc_wen            = commit & ~rst;
    assign misalign_exc      = commit & misalign_q & ~rst;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: directed vector table, reset-in-EXEC sequence and
// randomized instructions against a behavioural next-PC model.
// Expectations follow PC_MISALIGN_TRAP_EN when it is defined.
module tb_pc_seq_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_done, br_taken, jump, trap, mret;
    logic [31:0] jump_target, trap_vec, mepc;
    logic [31:0] pc, dnpc;
    logic        pc_wen, misalign_exc;
    logic [63:0] instret;

    pc_seq_ctrl_if #(.XLEN(32)) ifu_bus ();

    pc_seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ifu          (ifu_bus),
        .exu_done     (exu_done),
        .br_taken     (br_taken),
        .jump         (jump),
        .jump_target  (jump_target),
        .trap         (trap),
        .trap_vec     (trap_vec),
        .mret         (mret),
        .mepc         (mepc),
        .pc           (pc),
        .dnpc         (dnpc),
        .pc_wen       (pc_wen),
        .instret      (instret),
        .misalign_exc (misalign_exc)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_pc;
    logic [63:0] m_instret;

    typedef struct {
        int          rd, rs, dn;
        logic        b, j, t, m;
        logic [31:0] tg, tv, mp;
        logic [31:0] e_pc;
        logic        e_mis, e_ret;
    } vec_t;

    vec_t vecs[10];

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rand_redir();
        br_taken    = 1'($urandom);
        jump        = 1'($urandom);
        trap        = 1'($urandom);
        mret        = 1'($urandom);
        jump_target = $urandom;
        trap_vec    = $urandom;
        mepc        = $urandom;
    endtask

    // Next PC from the architectural rules: trap wins, then mret, then any
    // jump/taken branch, else fall through by one instruction.
    function automatic void model(input logic b, j, t, m,
                                  input logic [31:0] tg, tv, mp, cur,
                                  output logic [31:0] np,
                                  output logic mis, ret);
        logic [31:0] target;
        mis = 1'b0;
        ret = 1'b1;
        if (t) begin
            np  = tv;
            ret = 1'b0;
            return;
        end
        if (m)          target = mp;
        else if (j | b) target = tg;
        else begin
            np = cur + 32'd4;
            return;
        end
`ifdef PC_MISALIGN_TRAP_EN
        if (target % 4 != 0) begin
            np  = tv;
            mis = 1'b1;
            ret = 1'b0;
        end else begin
            np = target;
        end
`else
        np = target - (target % 4);
`endif
    endfunction

    // One full instruction: rd/rs/dn are extra wait cycles before ready,
    // resp_valid and exu_done. Inputs irrelevant to a phase get noise.
    task automatic do_instr(input int rd, rs, dn,
                            input logic b, j, t, m,
                            input logic [31:0] tg, tv, mp, e_pc,
                            input logic e_mis, e_ret);
        for (int i = 0; i <= rd; i++) begin
            @(negedge clk);
            check1("fetch_valid", ifu_bus.ifu_req_valid, 1'b1);
            check64("fetch_addr", 64'(ifu_bus.ifu_req_addr), 64'(m_pc));
            check1("fetch_no_wen", pc_wen, 1'b0);
            if (i == 0) begin
                check64("pc", 64'(pc), 64'(m_pc));
                check64("instret", instret, m_instret);
            end
            ifu_bus.ifu_req_ready  = (i == rd);
            ifu_bus.ifu_resp_valid = 1'($urandom);
            exu_done               = 1'($urandom);
            rand_redir();
        end
        for (int k = 0; k <= rs; k++) begin
            @(negedge clk);
            check1("wait_valid", ifu_bus.ifu_req_valid, 1'b0);
            check1("wait_no_wen", pc_wen, 1'b0);
            ifu_bus.ifu_req_ready  = 1'($urandom);
            ifu_bus.ifu_resp_valid = (k == rs);
            exu_done               = 1'($urandom);
            rand_redir();
        end
        for (int k = 0; k <= dn; k++) begin
            @(negedge clk);
            check1("exec_valid", ifu_bus.ifu_req_valid, 1'b0);
            check1("exec_no_wen", pc_wen, 1'b0);
            check1("exec_no_misalign", misalign_exc, 1'b0);
            ifu_bus.ifu_req_ready  = 1'($urandom);
            ifu_bus.ifu_resp_valid = 1'($urandom);
            exu_done               = (k == dn);
            if (k == dn) begin
                br_taken = b; jump = j; trap = t; mret = m;
                jump_target = tg; trap_vec = tv; mepc = mp;
            end else begin
                rand_redir();
            end
        end
        @(negedge clk);
        check1("commit_wen", pc_wen, 1'b1);
        check1("commit_valid", ifu_bus.ifu_req_valid, 1'b0);
        check64("commit_dnpc", 64'(dnpc), 64'(e_pc));
        check1("commit_misalign", misalign_exc, e_mis);
        check64("commit_pc_old", 64'(pc), 64'(m_pc));
        ifu_bus.ifu_req_ready  = 1'($urandom);
        ifu_bus.ifu_resp_valid = 1'($urandom);
        exu_done               = 1'($urandom);
        rand_redir();
        m_pc = e_pc;
        if (e_ret) m_instret = m_instret + 64'd1;
    endtask

    initial begin
        logic [31:0] np, tg, tv, mp;
        logic        mis, ret, b, j, t, m;

        vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h8000_0004, 0, 1};
        vecs[1] = '{0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h8000_0008, 0, 1};
        vecs[2] = '{0, 0, 0, 0, 1, 0, 0, 32'h8000_0100, 32'h0, 32'h0, 32'h8000_0100, 0, 1};
        vecs[3] = '{1, 0, 2, 0, 1, 1, 1, 32'h8000_0400, 32'h8000_0200, 32'h8000_0300, 32'h8000_0200, 0, 0};
        vecs[4] = '{0, 1, 0, 0, 1, 0, 1, 32'h8000_0400, 32'h8000_0200, 32'h8000_0300, 32'h8000_0300, 0, 1};
        vecs[5] = '{5, 2, 3, 1, 0, 0, 0, 32'h8000_0104, 32'h8000_0200, 32'h0, 32'h8000_0104, 0, 1};
`ifdef PC_MISALIGN_TRAP_EN
        vecs[6] = '{0, 0, 0, 0, 1, 0, 0, 32'h8000_0102, 32'h8000_0200, 32'h0, 32'h8000_0200, 1, 0};
`else
        vecs[6] = '{0, 0, 0, 0, 1, 0, 0, 32'h8000_0102, 32'h8000_0200, 32'h0, 32'h8000_0100, 0, 1};
`endif
        vecs[7] = '{0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'hFFFF_FFFC, 0, 1};
        vecs[8] = '{0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0000_0000, 0, 1};
        vecs[9] = '{2, 0, 1, 0, 0, 0, 0, 32'h1234_5678, 32'h0, 32'h0, 32'h0000_0004, 0, 1};

        rst = 1'b1;
        exu_done = 1'b0;
        ifu_bus.ifu_req_ready  = 1'b0;
        ifu_bus.ifu_resp_valid = 1'b0;
        br_taken = 1'b0; jump = 1'b0; trap = 1'b0; mret = 1'b0;
        jump_target = '0; trap_vec = '0; mepc = '0;

        @(posedge clk);
        @(negedge clk);
        check1("rst_req_valid", ifu_bus.ifu_req_valid, 1'b0);
        check1("rst_pc_wen", pc_wen, 1'b0);
        check1("rst_misalign", misalign_exc, 1'b0);
        check64("rst_pc", 64'(pc), 64'(RST_PC));
        check64("rst_dnpc", 64'(dnpc), 64'(RST_PC));
        check64("rst_instret", instret, 64'd0);
        rst = 1'b0;
        m_pc = RST_PC;
        m_instret = 64'd0;

        for (int v = 0; v < 10; v++)
            do_instr(vecs[v].rd, vecs[v].rs, vecs[v].dn,
                     vecs[v].b, vecs[v].j, vecs[v].t, vecs[v].m,
                     vecs[v].tg, vecs[v].tv, vecs[v].mp,
                     vecs[v].e_pc, vecs[v].e_mis, vecs[v].e_ret);

        // Reset while in EXEC aborts the instruction; a stale response
        // afterwards must not advance the fresh FETCH.
        @(negedge clk);
        ifu_bus.ifu_req_ready = 1'b1;
        @(negedge clk);
        ifu_bus.ifu_req_ready  = 1'b0;
        ifu_bus.ifu_resp_valid = 1'b1;
        @(negedge clk);
        check1("exec_before_rst_valid", ifu_bus.ifu_req_valid, 1'b0);
        ifu_bus.ifu_resp_valid = 1'b0;
        rst = 1'b1;
        exu_done = 1'b1;
        jump = 1'b1;
        jump_target = 32'h8000_0800;
        @(negedge clk);
        check64("midrst_pc", 64'(pc), 64'(RST_PC));
        check64("midrst_dnpc", 64'(dnpc), 64'(RST_PC));
        check64("midrst_instret", instret, 64'd0);
        check1("midrst_req_valid", ifu_bus.ifu_req_valid, 1'b0);
        check1("midrst_pc_wen", pc_wen, 1'b0);
        rst = 1'b0;
        exu_done = 1'b0;
        ifu_bus.ifu_resp_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check1("postrst_fetch_valid", ifu_bus.ifu_req_valid, 1'b1);
            check64("postrst_fetch_addr", 64'(ifu_bus.ifu_req_addr), 64'(RST_PC));
            check1("postrst_no_wen", pc_wen, 1'b0);
        end
        ifu_bus.ifu_resp_valid = 1'b0;
        m_pc = RST_PC;
        m_instret = 64'd0;
        do_instr(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h8000_0004, 0, 1);

        // Randomized instructions against the reference model.
        for (int n = 0; n < 60; n++) begin
            b = 1'($urandom_range(0, 3) == 0);
            j = 1'($urandom_range(0, 3) == 0);
            t = 1'($urandom_range(0, 5) == 0);
            m = 1'($urandom_range(0, 5) == 0);
            tg = $urandom;
            if ($urandom_range(0, 1) == 1) tg[1:0] = 2'b00;
            tv = $urandom & 32'hFFFF_FFFC;
            mp = $urandom;
            if ($urandom_range(0, 1) == 1) mp[1:0] = 2'b00;
            model(b, j, t, m, tg, tv, mp, m_pc, np, mis, ret);
            do_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     b, j, t, m, tg, tv, mp, np, mis, ret);
        end

        @(negedge clk);
        check64("final_pc", 64'(pc), 64'(m_pc));
        check64("final_instret", instret, m_instret);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
